instr_readback_checker: RTL and testbench

Self-checking reader for the instruction register stack. On a start pulse it walks read_pointer over a range of register locations and captures each instruction_word. It recomputes the expected result from opc/op_a/op_b, then streams each entry with a pass/fail flag over a valid/ready interface. It sits on the read side of the instruction register, opposite the load/write_pointer writer, and keeps a running mismatch count.

---
 rtl/instr_readback_checker.sv | 158 +++++++++++++++
 tb/tb_instr_readback_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_readback_checker.sv
// Read-side checker for the instruction register stack: walks read_pointer over a
// range, recomputes each result, and streams entries with a mismatch flag.
// Optional build macro STOP_ON_ERROR_EN ends the scan after the first mismatching entry.
module instr_readback_checker #(
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W:0]          count,
  output logic [ADDR_W-1:0]        read_pointer,
  input  logic [3:0]               iw_opc,
  input  logic signed [31:0]       iw_op_a,
  input  logic signed [31:0]       iw_op_b,
  input  logic signed [63:0]       iw_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic signed [63:0]       out_result,
  output logic signed [63:0]       out_expected,
  output logic                     out_mismatch,
  output logic                     busy,
  output logic                     done,
  output logic [ERR_W-1:0]         error_count
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_SEND  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [3:0] OPC_ZERO  = 4'd0;
  localparam logic [3:0] OPC_PASSA = 4'd1;
  localparam logic [3:0] OPC_PASSB = 4'd2;
  localparam logic [3:0] OPC_ADD   = 4'd3;
  localparam logic [3:0] OPC_SUB   = 4'd4;
  localparam logic [3:0] OPC_MULT  = 4'd5;
  localparam logic [3:0] OPC_DIV   = 4'd6;
  localparam logic [3:0] OPC_MOD   = 4'd7;

  localparam logic [1:0] LAT = 2'(RD_LAT);

  logic [2:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   remaining;
  logic [1:0]        wait_cnt;

  logic signed [63:0] a_ext, b_ext, exp_val;
  logic               bad_opc, mismatch_c, stop_now;

  // Reference model of the ALU. Division sits in if-statements rather than ?:
  // so an unsigned '0 arm can never turn the divide into an unsigned one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    a_ext   = {{32{iw_op_a[31]}}, iw_op_a};
    b_ext   = {{32{iw_op_b[31]}}, iw_op_b};
    exp_val = '0;
    bad_opc = 1'b0;
    case (iw_opc)
      OPC_ZERO:  exp_val = '0;
      OPC_PASSA: exp_val = a_ext;
      OPC_PASSB: exp_val = b_ext;
      OPC_ADD:   exp_val = a_ext + b_ext;
      OPC_SUB:   exp_val = a_ext - b_ext;
      OPC_MULT:  exp_val = a_ext * b_ext;
      OPC_DIV:   if (b_ext != 0) exp_val = a_ext / b_ext;
      OPC_MOD:   if (b_ext != 0) exp_val = a_ext % b_ext;
      default:   bad_opc = 1'b1;
    endcase
    mismatch_c = bad_opc || (iw_result != exp_val);
  end

`ifdef STOP_ON_ERROR_EN
  assign stop_now = out_mismatch;
`else
  assign stop_now = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments only, so every branch sees
  // start-of-cycle values; the asynchronous reset clears all of it, including outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cur_addr     <= '0;
      remaining    <= '0;
      wait_cnt     <= '0;
      read_pointer <= '0;
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_result   <= '0;
      out_expected <= '0;
      out_mismatch <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error_count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cur_addr    <= base_addr;
            remaining   <= count;
            error_count <= '0;
            busy        <= 1'b1;
            if (count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          read_pointer <= cur_addr;
          wait_cnt     <= LAT;
          state        <= (RD_LAT > 0) ? ST_WAIT : ST_CHECK;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 2'd1;
          if (wait_cnt <= 2'd1) state <= ST_CHECK;
        end
        ST_CHECK: begin
          out_addr     <= cur_addr;
          out_result   <= iw_result;
          out_expected <= exp_val;
          out_mismatch <= mismatch_c;
          out_valid    <= 1'b1;
          if (mismatch_c && (error_count != '1)) error_count <= error_count + 1'b1;
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            remaining <= remaining - 1'b1;
            cur_addr  <= cur_addr + 1'b1;
            if (stop_now || (remaining <= 1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ADDR;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_readback_checker.sv
// Directed bench for instr_readback_checker: a registered-read stack model feeds two
// instances (ERR_W=16 and ERR_W=2); expectations are hand-computed per entry.
module tb_instr_readback_checker;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [4:0]         base_addr;
  logic [5:0]         count;
  logic               out_ready;

  logic [4:0]         read_pointer, out_addr;
  logic               out_valid, out_mismatch, busy, done;
  logic signed [63:0] out_result, out_expected;
  logic [15:0]        error_count;

  logic [4:0]         rp2, out_addr2;
  logic               out_valid2, out_mismatch2, busy2, done2;
  logic signed [63:0] out_result2, out_expected2;
  logic [1:0]         error_count2;

  logic [3:0]         m_opc [32];
  logic signed [31:0] m_a [32], m_b [32];
  logic signed [63:0] m_res [32];

  logic [3:0]         d_opc, d2_opc;
  logic signed [31:0] d_a, d_b, d2_a, d2_b;
  logic signed [63:0] d_res, d2_res;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_acc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stack with one cycle of read latency, matching RD_LAT=1.
  always @(posedge clk) begin
    d_opc  <= m_opc[read_pointer];
    d_a    <= m_a[read_pointer];
    d_b    <= m_b[read_pointer];
    d_res  <= m_res[read_pointer];
    d2_opc <= m_opc[rp2];
    d2_a   <= m_a[rp2];
    d2_b   <= m_b[rp2];
    d2_res <= m_res[rp2];
  end

  instr_readback_checker #(.ADDR_W(5), .RD_LAT(1), .ERR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .count(count),
    .read_pointer(read_pointer), .iw_opc(d_opc), .iw_op_a(d_a), .iw_op_b(d_b),
    .iw_result(d_res), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_result(out_result), .out_expected(out_expected), .out_mismatch(out_mismatch),
    .busy(busy), .done(done), .error_count(error_count)
  );

  instr_readback_checker #(.ADDR_W(5), .RD_LAT(1), .ERR_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .count(count),
    .read_pointer(rp2), .iw_opc(d2_opc), .iw_op_a(d2_a), .iw_op_b(d2_b),
    .iw_result(d2_res), .out_valid(out_valid2), .out_ready(out_ready), .out_addr(out_addr2),
    .out_result(out_result2), .out_expected(out_expected2), .out_mismatch(out_mismatch2),
    .busy(busy2), .done(done2), .error_count(error_count2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int a, input logic [3:0] o, input logic signed [31:0] x,
                     input logic signed [31:0] y, input logic signed [63:0] r);
    m_opc[a] = o; m_a[a] = x; m_b[a] = y; m_res[a] = r;
  endtask

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic do_start(input logic [4:0] b, input logic [5:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    t_acc     = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // stall=0: out_ready is held high by the caller. stall>0: out_ready is low on entry.
  task automatic get_entry(input string tag, input logic [4:0] ea, input logic signed [63:0] er,
                           input logic signed [63:0] ee, input logic em, input int stall,
                           input bit poke);
    int n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_addr"}, 64'(out_addr), 64'(ea));
    check({tag, "_result"}, out_result, er);
    check({tag, "_expected"}, out_expected, ee);
    check({tag, "_mismatch"}, 64'(out_mismatch), 64'(em));
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        if (poke && i == 0) begin
          start = 1'b1; base_addr = 5'd5; count = 6'd0;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_stall_addr"}, 64'(out_addr), 64'(ea));
        check({tag, "_stall_expected"}, out_expected, ee);
        check({tag, "_stall_busy"}, 64'(busy), 64'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_released"}, 64'(out_valid), 64'd0);
    end else begin
      @(negedge clk);
    end
  endtask

  // exp_lat: edges from the start-accepting edge to the first cycle showing done (-1 skips).
  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    int extra = 0;
    while (done !== 1'b1 && n < 200) begin
      if (out_valid === 1'b1) extra++;
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    if (exp_lat >= 0) check({tag, "_latency"}, 64'(cyc - t_acc), 64'(exp_lat));
    check({tag, "_extra_entries"}, 64'(extra), 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_busy_off"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) put(i, 4'd0, 0, 0, 0);
    put(0, 4'd3, 5, 3, 8);
    put(1, 4'd4, -7, 2, -9);
    put(2, 4'd5, -4, 6, -24);
    put(4, 4'd6, 7, 0, 0);
    put(5, 4'd7, -7, 2, -1);
    put(9, 4'd3, 1, 1, 3);
    put(10, 4'd1, 100, 0, 99);
    put(11, 4'd9, 0, 0, 0);
    put(12, 4'd0, 0, 0, 5);
    put(13, 4'd2, 1, -2, 2);
    put(20, 4'd3, 2, 3, 5);
    put(21, 4'd4, 10, 4, 7);
    put(22, 4'd1, -1, 0, -1);
    put(23, 4'd5, 70000, 70000, 64'sd4900000000);
    put(24, 4'd6, -9, 2, -4);
    put(30, 4'd3, 32'sh7fffffff, 1, 64'sh80000000);
    put(31, 4'd4, 32'sh80000000, 1, -64'sd2147483649);

    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rp", 64'(read_pointer), 64'd0);
    check("rst_err", 64'(error_count), 64'd0);
    check("rst_result", out_result, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset during the second entry's WAIT cycle.
    out_ready = 1'b1;
    do_start(5'd0, 6'd4);
    repeat (5) @(negedge clk);
    check("midrst_pre_rp", 64'(read_pointer), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_rp", 64'(read_pointer), 64'd0);
    check("midrst_addr", 64'(out_addr), 64'd0);
    check("midrst_expected", out_expected, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", 64'(done), 64'd0);
      check("midrst_idle", 64'(busy), 64'd0);
    end

    // Full pass, out_ready held high.
    do_start(5'd0, 6'd3);
    check("pass_busy", 64'(busy), 64'd1);
    get_entry("pass0", 5'd0, 8, 8, 1'b0, 0, 1'b0);
    get_entry("pass1", 5'd1, -9, -9, 1'b0, 0, 1'b0);
    get_entry("pass2", 5'd2, -24, -24, 1'b0, 0, 1'b0);
    wait_done("pass", 12);
    check("pass_err", 64'(error_count), 64'd0);

    // Divide by zero and truncating modulo.
    do_start(5'd4, 6'd2);
    get_entry("div0", 5'd4, 0, 0, 1'b0, 0, 1'b0);
    get_entry("mod", 5'd5, -1, -1, 1'b0, 0, 1'b0);
    wait_done("divmod", -1);
    check("divmod_err", 64'(error_count), 64'd0);

    // Single mismatch.
    do_start(5'd9, 6'd1);
    get_entry("bad9", 5'd9, 3, 2, 1'b1, 0, 1'b0);
    wait_done("bad", -1);
    check("bad_err", 64'(error_count), 64'd1);
    check("bad_err2", 64'(error_count2), 64'd1);

    // count=0 clears error_count and finishes at once.
    do_start(5'd7, 6'd0);
    wait_done("cnt0", 0);
    check("cnt0_err", 64'(error_count), 64'd0);

    // Five bad entries: the 2-bit counter saturates at 3.
    do_start(5'd9, 6'd5);
    get_entry("sat9", 5'd9, 3, 2, 1'b1, 0, 1'b0);
`ifndef STOP_ON_ERROR_EN
    get_entry("sat10", 5'd10, 99, 100, 1'b1, 0, 1'b0);
    get_entry("sat11", 5'd11, 0, 0, 1'b1, 0, 1'b0);
    get_entry("sat12", 5'd12, 5, 0, 1'b1, 0, 1'b0);
    get_entry("sat13", 5'd13, 2, -2, 1'b1, 0, 1'b0);
    wait_done("sat", -1);
    check("sat_err", 64'(error_count), 64'd5);
    check("sat_err2", 64'(error_count2), 64'd3);
`else
    wait_done("sat", -1);
    check("sat_err", 64'(error_count), 64'd1);
    check("sat_err2", 64'(error_count2), 64'd1);
`endif

    // Mismatch on the second of five entries.
    do_start(5'd20, 6'd5);
    get_entry("stop20", 5'd20, 5, 5, 1'b0, 0, 1'b0);
    get_entry("stop21", 5'd21, 7, 6, 1'b1, 0, 1'b0);
`ifndef STOP_ON_ERROR_EN
    get_entry("stop22", 5'd22, -1, -1, 1'b0, 0, 1'b0);
    get_entry("stop23", 5'd23, 64'sd4900000000, 64'sd4900000000, 1'b0, 0, 1'b0);
    get_entry("stop24", 5'd24, -4, -4, 1'b0, 0, 1'b0);
`endif
    wait_done("stop", -1);
    check("stop_err", 64'(error_count), 64'd1);
    check("stop_err_held", 64'(error_count), 64'd1);

    // Wrap from 31 to 0 with three stall cycles per entry and a start pulse mid-scan.
    out_ready = 1'b0;
    do_start(5'd30, 6'd4);
    get_entry("wrap30", 5'd30, 64'sh80000000, 64'sh80000000, 1'b0, 3, 1'b0);
    get_entry("wrap31", 5'd31, -64'sd2147483649, -64'sd2147483649, 1'b0, 3, 1'b1);
    get_entry("wrap0", 5'd0, 8, 8, 1'b0, 3, 1'b0);
    get_entry("wrap1", 5'd1, -9, -9, 1'b0, 3, 1'b0);
    wait_done("wrap", -1);
    check("wrap_err", 64'(error_count), 64'd0);
    @(negedge clk);
    check("idle_rp_hold", 64'(read_pointer), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
